// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, light codes and timer width shared by the
// intersection controller and its tick synchroniser.
package traffic_pkg;

  localparam int TIMER_W = 4;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_t;

  // North-South lamp pattern for a phase; anything unexpected shows red.
  function automatic logic [2:0] ns_light_of(input phase_t p);
    case (p)
      NS_GREEN:  ns_light_of = LIGHT_GRN;
      NS_YELLOW: ns_light_of = LIGHT_YEL;
      default:   ns_light_of = LIGHT_RED;
    endcase
  endfunction

  // East-West lamp pattern for a phase; anything unexpected shows red.
  function automatic logic [2:0] ew_light_of(input phase_t p);
    case (p)
      EW_GREEN:  ew_light_of = LIGHT_GRN;
      EW_YELLOW: ew_light_of = LIGHT_YEL;
      default:   ew_light_of = LIGHT_RED;
    endcase
  endfunction

  // Fixed cycle order; an illegal encoding falls back to the all-red phase.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = ALLRED_A;
      ALLRED_A:  next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      EW_YELLOW: next_phase = ALLRED_B;
      ALLRED_B:  next_phase = NS_GREEN;
      default:   next_phase = ALLRED_B;
    endcase
  endfunction

endpackage

// File: rtl/tick_sync.sv
// tick_sync: brings the asynchronous 1 Hz sec_clk into CLK100MHZ through two
// flops and turns each rising edge into a single-cycle registered tick, which
// appears three system cycles after the sec_clk rise. Falling edges are ignored.
module tick_sync (
  input  logic CLK100MHZ,
  input  logic reset_n,
  input  logic sec_clk,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic tick_q,  tick_d;

  // Next values: shift sec_clk through the synchroniser and flag a 0->1 step.
  always_comb begin
    sync1_d = sec_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  // Synchroniser, edge-history and tick registers; reset empties the pipeline.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: sequences the NS/EW lights through green, yellow and
// all-red phases, counting seconds ticks derived from sec_clk. NS green is held
// while no East-West car waits. Optional pedestrian support is enabled by
// defining the macro PED_REQUEST_EN (adds ped_req / ped_walk ports).
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1,
  parameter int MIN_GREEN_SEC = 4
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic               sec_clk,
  input  logic               ew_car,
`ifdef PED_REQUEST_EN
  input  logic               ped_req,
  output logic               ped_walk,
`endif
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic [2:0]         phase,
  output logic [TIMER_W-1:0] secs_left
);

  localparam int TIMER_MAX = (1 << TIMER_W) - 1;

  if (GREEN_SEC < 1 || GREEN_SEC > TIMER_MAX) begin : g_bad_green
    $error("GREEN_SEC must be in 1..15");
  end
  if (YELLOW_SEC < 1 || YELLOW_SEC > TIMER_MAX) begin : g_bad_yellow
    $error("YELLOW_SEC must be in 1..15");
  end
  if (ALLRED_SEC < 1 || ALLRED_SEC > TIMER_MAX) begin : g_bad_allred
    $error("ALLRED_SEC must be in 1..15");
  end
  if (MIN_GREEN_SEC < 1 || MIN_GREEN_SEC > GREEN_SEC) begin : g_bad_min
    $error("MIN_GREEN_SEC must be in 1..GREEN_SEC");
  end

  localparam logic [TIMER_W-1:0] GREEN_T   = TIMER_W'(GREEN_SEC);
  localparam logic [TIMER_W-1:0] YELLOW_T  = TIMER_W'(YELLOW_SEC);
  localparam logic [TIMER_W-1:0] ALLRED_T  = TIMER_W'(ALLRED_SEC);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  function automatic logic [TIMER_W-1:0] duration_of(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   duration_of = GREEN_T;
      NS_YELLOW, EW_YELLOW: duration_of = YELLOW_T;
      default:              duration_of = ALLRED_T;
    endcase
  endfunction

  logic               tick;
  logic               cut;
  phase_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_eff;
  logic [2:0]         ns_light_q, ns_light_d;
  logic [2:0]         ew_light_q, ew_light_d;

  tick_sync u_tick (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .sec_clk   (sec_clk),
    .tick      (tick)
  );

  // Next phase and timer: count down on ticks, advance when a tick meets a
  // timer of one, hold NS green with no EW car unless a pedestrian cut applies.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timer_eff = cut ? TIMER_ONE : timer_q;
    case (state_q)
      NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B: begin
        if (!tick) begin
          timer_d = timer_eff;
        end else if (timer_eff != TIMER_ONE) begin
          timer_d = timer_q - TIMER_ONE;
        end else if (state_q == NS_GREEN && !ew_car && !cut) begin
          timer_d = TIMER_ONE;
        end else begin
          state_d = next_phase(state_q);
          timer_d = duration_of(state_d);
        end
      end
      default: begin
        state_d = ALLRED_B;
        timer_d = ALLRED_T;
      end
    endcase
    ns_light_d = ns_light_of(state_d);
    ew_light_d = ew_light_of(state_d);
  end

  // Phase, timer and lamp registers move together so lamps always match phase.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ALLRED_B;
      timer_q    <= ALLRED_T;
      ns_light_q <= LIGHT_RED;
      ew_light_q <= LIGHT_RED;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
    end
  end

`ifdef PED_REQUEST_EN
  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN_SEC);

  logic               latch_q, latch_d;
  logic               walk_q, walk_d;
  logic [TIMER_W-1:0] elapsed_q, elapsed_d;
  logic               in_green;
  logic               enter_allred;

  assign in_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);
  assign cut      = in_green && latch_q && (elapsed_q >= MIN_T);

  // Pedestrian bookkeeping: sticky request, ticks spent in green, walk lamp
  // lit for the whole all-red phase that follows a pending request.
  always_comb begin
    enter_allred = (state_d != state_q) &&
                   ((state_d == ALLRED_A) || (state_d == ALLRED_B));
    latch_d   = ped_req || (latch_q && !enter_allred);
    walk_d    = walk_q;
    elapsed_d = elapsed_q;
    if (enter_allred) begin
      walk_d = latch_q;
    end else if (state_d != ALLRED_A && state_d != ALLRED_B) begin
      walk_d = 1'b0;
    end
    if (state_d != state_q) begin
      elapsed_d = '0;
    end else if (tick && in_green && elapsed_q != '1) begin
      elapsed_d = elapsed_q + TIMER_ONE;
    end
  end

  // Pedestrian latch, walk lamp and green-elapsed counter registers.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      latch_q   <= 1'b0;
      walk_q    <= 1'b0;
      elapsed_q <= '0;
    end else begin
      latch_q   <= latch_d;
      walk_q    <= walk_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign ped_walk = walk_q;
`else
  assign cut = 1'b0;
`endif

  assign ns_light  = ns_light_q;
  assign ew_light  = ew_light_q;
  assign phase     = state_q;
  assign secs_left = timer_q;

endmodule
